// File: rtl/drbg_keystream_buffer_pkg.sv
// Shared types and defaults for the DRBG keystream buffer.
//   fetch_state_t : states of the DRBG fetch/reseed FSM
//   *_DEF         : default parameter values used by the top level
//   KEYS_PER_WORD : keys carved out of one default-sized DRBG word
//   idx_width()   : index width for a count of items, never below 1 bit
package keystream_pkg;

    localparam int unsigned WORD_W_DEF       = 256;
    localparam int unsigned KEY_W_DEF        = 16;
    localparam int unsigned DEPTH_DEF        = 4;
    localparam int unsigned RESEED_WORDS_DEF = 1024;
    localparam int unsigned KEYS_PER_WORD    = WORD_W_DEF / KEY_W_DEF;
    localparam int unsigned WSR_W            = 32;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_REQ_NEXT    = 3'd1,
        ST_WAIT_NEXT   = 3'd2,
        ST_REQ_RESEED  = 3'd3,
        ST_WAIT_RESEED = 3'd4
    } fetch_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/drbg_keystream_buffer_fifo.sv
// kbuf_fifo: synchronous word FIFO holding prefetched DRBG words.
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i/wdata_i : write one word (caller guarantees not full)
//   pop_i          : drop the head word (caller guarantees not empty)
//   head_o         : current head word (no bypass: a pushed word shows up
//                    only after the write edge)
//   count_o        : number of words held
module kbuf_fifo #(
    parameter  int unsigned WIDTH = 256,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/drbg_keystream_buffer.sv
// drbg_keystream_buffer: prefetches DRBG words into a FIFO, serialises them
// MSB-first into KEY_W-bit keys and schedules periodic reseeds.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   drbg_busy_i             : DRBG busy
//   drbg_next_ready_i       : DRBG has a fresh word on drbg_random_bits_i
//   drbg_random_bits_i      : DRBG output word
//   drbg_next_o             : level request for a new word, held until busy seen
//   drbg_reseed_o           : level request for a reseed, held until busy seen
//   key_valid_o/key_ready_i : key stream handshake
//   key_o                   : current key
//   fill_level_o            : words held in the FIFO
//   starve_o                : consumer ready with no key, after first capture
//   words_since_reseed_o    : words captured since the last completed reseed
module drbg_keystream_buffer
    import keystream_pkg::*;
#(
    parameter  int unsigned WORD_W       = WORD_W_DEF,
    parameter  int unsigned KEY_W        = KEY_W_DEF,
    parameter  int unsigned DEPTH        = DEPTH_DEF,
    parameter  int unsigned RESEED_WORDS = RESEED_WORDS_DEF,
    localparam int unsigned FILL_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              drbg_busy_i,
    input  logic              drbg_next_ready_i,
    input  logic [WORD_W-1:0] drbg_random_bits_i,
    output logic              drbg_next_o,
    output logic              drbg_reseed_o,
    output logic              key_valid_o,
    input  logic              key_ready_i,
    output logic [KEY_W-1:0]  key_o,
    output logic [FILL_W-1:0] fill_level_o,
    output logic              starve_o,
    output logic [WSR_W-1:0]  words_since_reseed_o
);

    localparam int unsigned KPW   = WORD_W / KEY_W;
    localparam int unsigned IDX_W = idx_width(KPW);

    fetch_state_t      state_q, state_d;
    logic [WSR_W-1:0]  wsr_q, wsr_d;
    logic [IDX_W-1:0]  kidx_q, kidx_d;
    logic              next_q, reseed_q, armed_q;
    logic              push, pop, beat, last_key, inflight;
    logic [FILL_W:0]   occupancy;
    logic [WORD_W-1:0] head;
    logic [FILL_W-1:0] fill;
    logic [KEY_W-1:0]  key_lane [KPW];

    kbuf_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .wdata_i (drbg_random_bits_i),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (fill)
    );

    // Counting the outstanding request means a capture can never hit a full FIFO.
    assign inflight  = (state_q == ST_REQ_NEXT) || (state_q == ST_WAIT_NEXT);
    assign occupancy = {1'b0, fill} + {{FILL_W{1'b0}}, inflight};

    always_comb begin
        state_d = state_q;
        wsr_d   = wsr_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!drbg_busy_i) begin
                    if ((RESEED_WORDS != 0) && (wsr_q >= WSR_W'(RESEED_WORDS))) begin
                        state_d = ST_REQ_RESEED;
                    end else if (occupancy < (FILL_W + 1)'(DEPTH)) begin
                        state_d = ST_REQ_NEXT;
                    end
                end
            end
            ST_REQ_NEXT: begin
                if (drbg_busy_i) state_d = ST_WAIT_NEXT;
            end
            // Only reachable after busy was seen high, so a next_ready left
            // over from before a reset is never mistaken for a fresh word.
            ST_WAIT_NEXT: begin
                if (!drbg_busy_i && drbg_next_ready_i) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                    if (wsr_q != '1) wsr_d = wsr_q + WSR_W'(1);
                end
            end
            ST_REQ_RESEED: begin
                if (drbg_busy_i) state_d = ST_WAIT_RESEED;
            end
            ST_WAIT_RESEED: begin
                if (!drbg_busy_i) begin
                    wsr_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Key lanes of the head word, lane 0 being the most significant slice.
    for (genvar gi = 0; gi < KPW; gi++) begin : g_lane
        assign key_lane[gi] = head[WORD_W-1-gi*KEY_W -: KEY_W];
    end

    assign key_valid_o = (fill != '0);
    assign beat        = key_valid_o && key_ready_i;
    assign last_key    = (kidx_q == IDX_W'(KPW - 1));
    assign pop         = beat && last_key;

    always_comb begin
        kidx_d = kidx_q;
        if (beat) kidx_d = last_key ? '0 : kidx_q + IDX_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            wsr_q    <= '0;
            kidx_q   <= '0;
            next_q   <= 1'b0;
            reseed_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wsr_q    <= wsr_d;
            kidx_q   <= kidx_d;
            // Requests are registered images of the next state, so the two
            // can never be high together.
            next_q   <= (state_d == ST_REQ_NEXT);
            reseed_q <= (state_d == ST_REQ_RESEED);
            if (push) armed_q <= 1'b1;
        end
    end

    assign drbg_next_o          = next_q;
    assign drbg_reseed_o        = reseed_q;
    assign key_o                = key_valid_o ? key_lane[kidx_q] : '0;
    assign fill_level_o         = fill;
    assign starve_o             = armed_q && key_ready_i && !key_valid_o;
    assign words_since_reseed_o = wsr_q;

endmodule

// File: tb/tb_drbg_keystream_buffer.sv
module tb_drbg_keystream_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         drbg_busy = 1'b1;
    logic         drbg_next_ready = 1'b0;
    logic [255:0] drbg_random_bits = '0;
    logic         drbg_next, drbg_reseed, key_valid, starve;
    logic         key_ready = 1'b0;
    logic [15:0]  key;
    logic [2:0]   fill_level;
    logic [31:0]  words_since_reseed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    drbg_keystream_buffer #(
        .WORD_W       (256),
        .KEY_W        (16),
        .DEPTH        (4),
        .RESEED_WORDS (3)
    ) dut (
        .clk_i                (clk),
        .reset_i              (reset),
        .drbg_busy_i          (drbg_busy),
        .drbg_next_ready_i    (drbg_next_ready),
        .drbg_random_bits_i   (drbg_random_bits),
        .drbg_next_o          (drbg_next),
        .drbg_reseed_o        (drbg_reseed),
        .key_valid_o          (key_valid),
        .key_ready_i          (key_ready),
        .key_o                (key),
        .fill_level_o         (fill_level),
        .starve_o             (starve),
        .words_since_reseed_o (words_since_reseed)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Hand-written keys of word 0, MSB first.
    localparam logic [15:0] W0_KEYS [16] = '{
        16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210,
        16'h0011, 16'h2233, 16'h4455, 16'h6677, 16'h8899, 16'hAABB, 16'hCCDD, 16'hEEFF};

    function automatic logic [255:0] word_of(input int unsigned n);
        logic [255:0] w;
        if (n == 0)
            return 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
        w = '0;
        for (int i = 0; i < 16; i++) w[255-16*i -: 16] = {n[7:0], 8'(i)};
        return w;
    endfunction

    function automatic logic [15:0] exp_key(input int w, input int k);
        if (w == 0) return W0_KEYS[k];
        return {w[7:0], k[7:0]};
    endfunction

    // ---------------- DRBG model ----------------
    int unsigned m_lat = 2;
    bit          m_hold = 1'b0;
    bit          m_init_on_reset = 1'b1;
    int          m_cnt = 0;
    int          m_op = 0;          // 0 none, 1 next pending, 2 reseed pending
    int unsigned m_words = 0;
    byte         m_log [$];

    always @(posedge clk) begin
        if (reset && m_init_on_reset) begin
            drbg_busy       <= 1'b1;
            drbg_next_ready <= 1'b0;
            m_cnt           <= 20;
            m_op            <= 0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                drbg_busy <= 1'b0;
                if (m_op == 1) begin
                    drbg_next_ready  <= 1'b1;
                    drbg_random_bits <= word_of(m_words);
                    m_words          <= m_words + 1;
                end
                m_op <= 0;
            end
            m_cnt <= m_cnt - 1;
        end else if (!m_hold && !drbg_busy) begin
            if (drbg_next) begin
                drbg_busy       <= 1'b1;
                drbg_next_ready <= 1'b0;
                m_cnt           <= int'(m_lat);
                m_op            <= 1;
                m_log.push_back(8'h4E);
            end else if (drbg_reseed) begin
                drbg_busy       <= 1'b1;
                drbg_next_ready <= 1'b0;
                m_cnt           <= 5;
                m_op            <= 2;
                m_log.push_back(8'h52);
            end
        end
    end

    // ---------------- output monitor ----------------
    int          exp_w = 0, exp_k = 0;
    bit          mon_en = 1'b1;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_key = '0;
    int          stab_err = 0, stall_cnt = 0, starve_cnt = 0, starve_bad = 0, both_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (starve) starve_cnt++;
                if (starve && key_valid) starve_bad++;
                if (drbg_next && drbg_reseed) both_err++;
                if (mon_en) begin
                    if (prev_stall && (key !== prev_key || key_valid !== 1'b1)) stab_err++;
                    prev_stall = key_valid && !key_ready;
                    if (prev_stall) stall_cnt++;
                    prev_key = key;
                    if (key_valid && key_ready) begin
                        chk($sformatf("key w%0d k%0d", exp_w, exp_k), 64'(key), 64'(exp_key(exp_w, exp_k)));
                        if (exp_k == 15) begin
                            exp_k = 0;
                            exp_w++;
                        end else begin
                            exp_k++;
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int bad;
        int base;
        bit ok;
        int unsigned fresh;

        // Test 1: reset, DRBG init busy, fill to DEPTH
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_key_valid", 64'(key_valid), 64'd0);
        chk("rst_fill", 64'(fill_level), 64'd0);
        chk("rst_next", 64'(drbg_next), 64'd0);
        chk("rst_reseed", 64'(drbg_reseed), 64'd0);
        chk("rst_wsr", 64'(words_since_reseed), 64'd0);
        chk("rst_key", 64'(key), 64'd0);
        key_ready = 1'b1;
        cyc = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 15) key_ready = 1'b0;
            if (drbg_next) begin
                ok = 1'b1;
                break;
            end
        end
        key_ready = 1'b0;
        chk("first_next_seen", 64'(ok), 64'd1);
        chk("first_next_cycle", 64'(cyc), 64'd22);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (fill_level == 3'd4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fill_to_4", 64'(ok), 64'd1);
        chk("no_starve_before_data", 64'(starve_cnt), 64'd0);
        chk("full_wsr", 64'(words_since_reseed), 64'd1);
        chk("full_key0", 64'(key), 64'h0123);
        // Test 4: reseed after the 3rd capture, before the 4th request
        chk("log_len", 64'(m_log.size()), 64'd5);
        if (m_log.size() == 5) begin
            chk("log0", 64'(m_log[0]), 64'h4E);
            chk("log1", 64'(m_log[1]), 64'h4E);
            chk("log2", 64'(m_log[2]), 64'h4E);
            chk("log3", 64'(m_log[3]), 64'h52);
            chk("log4", 64'(m_log[4]), 64'h4E);
        end
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (drbg_next || drbg_reseed || fill_level != 3'd4) bad++;
        end
        chk("idle_when_full", 64'(bad), 64'd0);

        // Test 2: ready held high for exactly one word
        @(posedge clk);
        #1 key_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_w == 1) begin
                ok = 1'b1;
                break;
            end
        end
        key_ready = 1'b0;
        chk("word0_done", 64'(ok), 64'd1);
        @(negedge clk);
        chk("pop_after_16", 64'(key), 64'h0100);
        chk("valid_after_pop", 64'(key_valid), 64'd1);

        // Test 3: random ready, words 1..3
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (exp_w == 4) begin
                ok = 1'b1;
                break;
            end
            key_ready = 1'($urandom_range(0, 1));
        end
        key_ready = 1'b0;
        chk("random_ready_done", 64'(ok), 64'd1);
        chk("stall_seen", 64'(stall_cnt > 0), 64'd1);
        chk("key_stable_on_stall", 64'(stab_err), 64'd0);
        chk("wsr_in_range", 64'(words_since_reseed <= 3), 64'd1);

        // Test 5: slow DRBG drains the FIFO, starve must pulse
        m_lat = 200;
        base = starve_cnt;
        key_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            if (starve_cnt - base >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        chk("starve_pulses", 64'(ok), 64'd1);
        chk("starve_only_when_empty", 64'(starve_bad), 64'd0);
        chk("never_next_and_reseed", 64'(both_err), 64'd0);

        // Test 6: reset while a word is in flight
        #1 key_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (m_op == 1 && m_cnt > 100) begin
                ok = 1'b1;
                break;
            end
        end
        chk("inflight_found", 64'(ok), 64'd1);
        mon_en = 1'b0;
        m_init_on_reset = 1'b0;
        m_hold = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("mid_rst_fill", 64'(fill_level), 64'd0);
        chk("mid_rst_valid", 64'(key_valid), 64'd0);
        chk("mid_rst_wsr", 64'(words_since_reseed), 64'd0);
        chk("mid_rst_next", 64'(drbg_next), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (m_cnt == 0 && drbg_next_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("stale_delivered", 64'(ok), 64'd1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (fill_level != 3'd0 || key_valid) bad++;
        end
        chk("stale_not_captured", 64'(bad), 64'd0);
        chk("new_request_pending", 64'(drbg_next), 64'd1);
        fresh = m_words;
        m_lat = 3;
        m_hold = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fresh_captured", 64'(ok), 64'd1);
        chk("fresh_key", 64'(key), 64'({fresh[7:0], 8'h00}));
        chk("fresh_fill", 64'(fill_level), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
